// File: rtl/check_level_if.sv
// Command/result bundle between the check sequencer (master) and check_level (slave).
interface check_level_if #(
  parameter int CHECK_SIZE    = 5,
  parameter int CHECK_WIDTH   = 32,
  parameter int TIMEOUT_WIDTH = 16
);
  localparam int IDX_W = (CHECK_SIZE > 1) ? $clog2(CHECK_SIZE) : 1;

  logic                                   i_sel_check;
  logic                                   i_args_valid;
  logic [IDX_W-1:0]                       i_check_idx;
  logic [CHECK_WIDTH-1:0]                 i_expected;
  logic [CHECK_WIDTH-1:0]                 i_mask;
  logic [TIMEOUT_WIDTH-1:0]               i_timeout;
  logic [CHECK_SIZE-1:0][CHECK_WIDTH-1:0] i_check;

  logic                                   o_busy;
  logic                                   o_check_done;
  logic                                   o_check_pass;
  logic                                   o_cmd_dropped;
  logic [15:0]                            o_check_count;
  logic [15:0]                            o_error_count;
  logic [CHECK_WIDTH-1:0]                 o_last_fail_value;

  modport master (
    output i_sel_check, i_args_valid, i_check_idx, i_expected, i_mask, i_timeout, i_check,
    input  o_busy, o_check_done, o_check_pass, o_cmd_dropped,
           o_check_count, o_error_count, o_last_fail_value
  );

  modport slave (
    input  i_sel_check, i_args_valid, i_check_idx, i_expected, i_mask, i_timeout, i_check,
    output o_busy, o_check_done, o_check_pass, o_cmd_dropped,
           o_check_count, o_error_count, o_last_fail_value
  );
endinterface

// File: rtl/check_level.sv
// Masked compare of one live channel against an expected value, retried for up to
// i_timeout extra cycles; reports a one-cycle done pulse plus pass/fail statistics.
module check_level #(
  parameter int CHECK_SIZE    = 5,
  parameter int CHECK_WIDTH   = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  check_level_if.slave  bus
);
  localparam int IDX_W = (CHECK_SIZE > 1) ? $clog2(CHECK_SIZE) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] WINDOW = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [CHECK_WIDTH-1:0]   r_exp;
  logic [CHECK_WIDTH-1:0]   r_mask;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_pass;
  logic                     r_dropped;
  logic [15:0]              r_check_count;
  logic [15:0]              r_error_count;
  logic [CHECK_WIDTH-1:0]   r_last_fail;

  logic                     w_cmd;
  logic                     w_idx_ok;
  logic                     w_match;
  logic                     w_finish;
  logic [CHECK_WIDTH-1:0]   w_sample;

  assign w_cmd = bus.i_args_valid & bus.i_sel_check;

  // Out-of-range index selects nothing: sample reads as zero and can never match.
  always_comb begin
    w_sample = '0;
    w_idx_ok = 1'b0;
    for (int i = 0; i < CHECK_SIZE; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sample = bus.i_check[i];
        w_idx_ok = 1'b1;
      end
    end
  end

  assign w_match = w_idx_ok && ((w_sample & r_mask) == r_exp);

  always_comb begin
    w_finish = 1'b0;
    case (r_state)
      SAMPLE:  w_finish = w_match || !w_idx_ok || (r_timeout == '0);
      WINDOW:  w_finish = w_match || (r_cnt == TIMEOUT_WIDTH'(1));
      default: w_finish = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_exp         <= '0;
      r_mask        <= '0;
      r_timeout     <= '0;
      r_cnt         <= '0;
      r_pass        <= 1'b0;
      r_dropped     <= 1'b0;
      r_check_count <= '0;
      r_error_count <= '0;
      r_last_fail   <= '0;
    end else begin
      r_dropped <= w_cmd && (r_state != IDLE);

      case (r_state)
        IDLE: begin
          if (w_cmd) begin
            r_idx     <= bus.i_check_idx;
            r_exp     <= bus.i_expected & bus.i_mask;
            r_mask    <= bus.i_mask;
            r_timeout <= bus.i_timeout;
            r_state   <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (w_finish) begin
            r_state <= DONE;
          end else begin
            r_cnt   <= r_timeout;
            r_state <= WINDOW;
          end
        end
        WINDOW: begin
          if (w_finish) r_state <= DONE;
          else          r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase

      // Results land on the edge entering DONE so they are visible with the done pulse.
      if (w_finish) begin
        r_pass <= w_match;
        if (r_check_count != 16'hFFFF) r_check_count <= r_check_count + 16'd1;
        if (!w_match) begin
          r_last_fail <= w_sample;
          if (r_error_count != 16'hFFFF) r_error_count <= r_error_count + 16'd1;
        end
      end
    end
  end

  assign bus.o_busy            = (r_state != IDLE);
  assign bus.o_check_done      = (r_state == DONE);
  assign bus.o_check_pass      = r_pass;
  assign bus.o_cmd_dropped     = r_dropped;
  assign bus.o_check_count     = r_check_count;
  assign bus.o_error_count     = r_error_count;
  assign bus.o_last_fail_value = r_last_fail;
endmodule

// File: doc/check_level.md
CHECK_LEVEL -- requirements
Module: check_level

Interface
REQ-001 Parameter CHECK_SIZE, default 5, number of observed check channels.
REQ-002 Parameter CHECK_WIDTH, default 32, width of each check channel and of expected/mask values.
REQ-003 Parameter TIMEOUT_WIDTH, default 16, width of the timeout field and window counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_sel_check  in  1  decoder selects a CHECK command.
REQ-007 i_args_valid  in  1  one-cycle command strobe from sequencer.
REQ-008 i_check_idx  in  $clog2(CHECK_SIZE)  channel to check.
REQ-009 i_expected  in  CHECK_WIDTH  expected value.
REQ-010 i_mask  in  CHECK_WIDTH  compare mask; 1 = bit compared.
REQ-011 i_timeout  in  TIMEOUT_WIDTH  extra sample cycles allowed; 0 = single-sample check.
REQ-012 i_check  in  CHECK_SIZE x CHECK_WIDTH  observed DUT signals.
REQ-013 o_busy  out  1  high while a check is in progress.
REQ-014 o_check_done  out  1  one-cycle completion pulse; acknowledges the command to the decoder.
REQ-015 o_check_pass  out  1  result of the last completed check.
REQ-016 o_cmd_dropped  out  1  one-cycle pulse when a command arrives while busy.
REQ-017 o_check_count  out  16  number of completed checks.
REQ-018 o_error_count  out  16  number of failed checks.
REQ-019 o_last_fail_value  out  CHECK_WIDTH  sampled channel value at the last failure.

Function
REQ-020 The state machine SHALL use the states IDLE, SAMPLE, WINDOW and DONE.
REQ-021 Accept: i_args_valid & i_sel_check in IDLE; on accept, capture idx, expected & mask, mask and timeout, then go to SAMPLE.
REQ-022 i_args_valid without i_sel_check SHALL be ignored in every state.
REQ-023 Match condition: (i_check[idx] & mask) == (expected & mask); mask all-zero always matches.
REQ-024 In SAMPLE: on match -> DONE with pass=1; on mismatch with timeout=0 -> DONE with pass=0; on mismatch with timeout>0 -> WINDOW with counter loaded to timeout.
REQ-025 In WINDOW, each cycle: on match -> DONE with pass=1; else if counter==1 -> DONE with pass=0; else decrement the counter. Total samples = timeout+1.
REQ-026 Captured i_check_idx >= CHECK_SIZE SHALL go directly from SAMPLE to DONE with pass=0 and o_last_fail_value=0.
REQ-027 In DONE: o_check_done=1 for exactly one cycle, o_check_pass updated, counters updated, then return to IDLE.
REQ-028 Latency: a pass on the first sample SHALL assert o_check_done 2 cycles after the accept cycle; a pass on window sample k (1..timeout) SHALL assert it 2+k cycles after accept.
REQ-029 o_check_pass and o_last_fail_value SHALL hold their values until the next DONE.
REQ-030 o_busy SHALL be high in SAMPLE, WINDOW and DONE.
REQ-031 o_check_count SHALL increment on every DONE; o_error_count SHALL increment on every failing DONE; both saturate at 0xFFFF.
REQ-032 A command (i_args_valid & i_sel_check) arriving while not in IDLE SHALL be dropped with an o_cmd_dropped pulse and SHALL NOT affect the check in progress.
REQ-033 A command in the same cycle as the DONE state SHALL be dropped; it is accepted only in IDLE.
REQ-034 i_check SHALL be sampled live each cycle; it is never latched at accept.

Reset
REQ-035 While rst=1: state=IDLE, o_busy=0, o_check_done=0, o_check_pass=0, o_cmd_dropped=0, both counts=0, o_last_fail_value=0, window counter=0.
REQ-036 rst asserted mid-check SHALL abort the check at the next edge with no o_check_done pulse and no count update.

Verification
REQ-037 Channel 2 = 0x0000_00A5; check idx=2, exp=0xA5, mask=0xFF, timeout=0 -> done 2 cycles after accept, pass=1, check_count=1, error_count=0.
REQ-038 Channel 0 = 0x12; exp=0x34, mask=0xFF, timeout=0 -> done at +2, pass=0, last_fail_value=0x12, error_count=1.
REQ-039 Timeout=5, channel becomes a match 3 cycles after SAMPLE -> pass=1, done at +5; a repeat check where the channel never matches -> pass=0, done at +7.
REQ-040 Second command issued 1 cycle after accept -> o_cmd_dropped pulse, first check completes unchanged, check_count increments by 1 only.
REQ-041 idx=7 with CHECK_SIZE=5 -> done at +2, pass=0, error_count increments; mask=0 with any value -> pass=1.
REQ-042 rst pulsed during WINDOW -> no done pulse, all outputs at reset values; a following check runs normally.
